// File: rtl/rom_scan_ctrl_pkg.sv
// Shared constants and state encoding for the ROM scan sequencer.
package rom_scan_ctrl_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int SUM_W  = DATA_W + ADDR_W;
  localparam int LEN_W  = ADDR_W + 1;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // A window longer than the ROM would revisit words, so it is cut to one full lap.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/rom_scan_ctrl_if.sv
// Control handshake plus ROM address/data bus of the scan sequencer.
interface rom_scan_ctrl_if;
  import rom_scan_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] max_val;
  logic [ADDR_W-1:0] max_addr;
  logic [ADDR_W-1:0] Rom_addr;
  logic [DATA_W-1:0] Rom_data;

  // Lab control plus ROM side: issues requests, returns ROM data.
  modport master (
    output start, base_addr, length, Rom_data,
    input  busy, done, sum, max_val, max_addr, Rom_addr
  );

  // Scan sequencer side.
  modport slave (
    input  start, base_addr, length, Rom_data,
    output busy, done, sum, max_val, max_addr, Rom_addr
  );

endinterface

// File: rtl/rom_scan_ctrl.sv
// Walks a wrapping window of ROM addresses, one word per cycle, and
// accumulates sum, maximum and address of the first maximum.
module rom_scan_ctrl
  import rom_scan_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  rom_scan_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_first;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_max_val;
  logic [ADDR_W-1:0] r_max_addr;
  logic              r_busy;
  logic              r_done;
  logic              w_last;

  assign w_last = (r_remaining == LEN_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves w_next_state unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (bus.start) w_next_state = (bus.length == '0) ? DONE : SCAN;
      SCAN: if (w_last)    w_next_state = DONE;
      DONE:                w_next_state = IDLE;
      default:             w_next_state = IDLE;
    endcase
  end

  // Address walk, accumulators and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr  <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_sum       <= '0;
      r_max_val   <= '0;
      r_max_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_rom_addr <= bus.base_addr;
            r_sum      <= '0;
            r_max_val  <= '0;
            if (bus.length != '0) begin
              r_remaining <= clamp_len(bus.length);
              r_first     <= 1'b1;
              r_max_addr  <= '0;
            end else begin
              // Empty window reports its base as the (vacuous) max location.
              r_max_addr <= bus.base_addr;
            end
          end
        end
        SCAN: begin
          r_sum <= r_sum + SUM_W'(bus.Rom_data);
          // Strict compare keeps the earliest address on ties.
          if (r_first || (bus.Rom_data > r_max_val)) begin
            r_max_val  <= bus.Rom_data;
            r_max_addr <= r_rom_addr;
          end
          r_first     <= 1'b0;
          r_remaining <= r_remaining - LEN_W'(1);
          // Address stays on the last word so it still points into the window.
          if (!w_last) r_rom_addr <= r_rom_addr + ADDR_W'(1);
        end
        default: ;
      endcase
      r_busy <= (w_next_state != IDLE);
      r_done <= (w_next_state == DONE);
    end
  end

  assign bus.Rom_addr = r_rom_addr;
  assign bus.sum      = r_sum;
  assign bus.max_val  = r_max_val;
  assign bus.max_addr = r_max_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
